// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//   Memory-side responder for the core's data load/store port. Holds a
//   word-organised data RAM and serves one request at a time over a
//   valid/ready request channel and a valid/ready response channel, with a
//   programmable access latency (accept edge to rsp_valid edge).
//
// Parameters
//   DEPTH_WORDS  number of 32-bit words (byte range 0..4*DEPTH_WORDS-1), >= 2
//   LATENCY      accept-to-response latency in cycles, 1..15
//
// Ports
//   clk        in   1   clock, all logic on posedge
//   reset      in   1   asynchronous, active-high reset
//   req_valid  in   1   request present
//   req_ready  out  1   responder can accept a request
//   req_we     in   1   1 = store, 0 = load
//   req_wstrb  in   4   byte-lane enables for stores (bit i -> wdata[8i+7:8i])
//   req_addr   in   32  byte address
//   req_wdata  in   32  store data
//   rsp_valid  out  1   response present
//   rsp_ready  in   1   requester accepts the response
//   rsp_rdata  out  32  load data (0 for stores and errors)
//   rsp_err    out  1   misaligned or out-of-range access
//
// States
//   state   | meaning
//   ST_IDLE | ready for a request; request fields latched on accept
//   ST_WAIT | latency countdown; access executes on the edge leaving WAIT
//   ST_RESP | response held until rsp_ready
// ---------------------------------------------------------------------------
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [3:0]  req_wstrb,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          AW         = $clog2(DEPTH_WORDS);
  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  CNT_LOAD   = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [3:0]  r_wstrb;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_req_ready;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;

  logic [31:0] r_mem [DEPTH_WORDS];

  logic          w_err;
  logic [AW-1:0] w_idx;
  logic          w_exec;

  // Decode works on the latched request so the requester may change its
  // inputs as soon as the request has been accepted.
  assign w_err  = (r_addr[1:0] != 2'b00) || ({1'b0, r_addr} >= ADDR_LIMIT);
  assign w_idx  = r_addr[AW+1:2];
  // The counter is loaded with LATENCY-1 and WAIT is left once it reaches
  // zero, so the access lands exactly LATENCY edges after the accept edge
  // (LATENCY=1 spends a single cycle in WAIT with the counter already 0).
  assign w_exec = (r_state == ST_WAIT) && (r_cnt == 4'd0);

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

  // RAM is deliberately not reset. A reset while in WAIT forces r_state to
  // IDLE asynchronously, so w_exec cannot fire for the dropped store.
  always_ff @(posedge clk) begin
    if (w_exec && r_we && !w_err) begin
      for (int i = 0; i < 4; i++) begin
        if (r_wstrb[i]) begin
          r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 4'd0;
      r_we        <= 1'b0;
      r_wstrb     <= 4'd0;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // req_ready comes up on the first edge after reset release.
          r_req_ready <= 1'b1;
          if (req_valid && r_req_ready) begin
            r_we        <= req_we;
            r_wstrb     <= req_wstrb;
            r_addr      <= req_addr;
            r_wdata     <= req_wdata;
            r_cnt       <= CNT_LOAD;
            r_req_ready <= 1'b0;
            r_state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state     <= ST_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= w_err;
            // Load data is the word as it stands on this edge; stores and
            // errored accesses return zero.
            r_rsp_rdata <= (r_we || w_err) ? 32'd0 : r_mem[w_idx];
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_state     <= ST_IDLE;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
            r_req_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_req_ready <= 1'b0;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  a_excl_handshake: assert property (@(posedge clk) disable iff (reset)
    !(rsp_valid && req_ready));

  a_rsp_stable: assert property (@(posedge clk) disable iff (reset)
    (rsp_valid && !rsp_ready) |=> ($stable(rsp_rdata) && $stable(rsp_err)));
`endif

endmodule
